// File: rtl/flappy_pkg.sv
// Shared game definitions: FSM state encoding, screen constants and default geometry
// used by the pipe, bird, collision and draw stages.
package flappy_pkg;

  // One-hot so each state bit can drive a status output directly.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StPlay = 3'b010,
    StLost = 3'b100
  } game_state_e;

  localparam int unsigned ScreenW  = 800;
  localparam int unsigned ScreenH  = 525;
  localparam int unsigned PipePark = 1000;

  localparam int unsigned BirdXDef   = 200;
  localparam int unsigned BirdWDef   = 20;
  localparam int unsigned BirdHDef   = 20;
  localparam int unsigned PipeWDef   = 50;
  localparam int unsigned GapHDef    = 120;
  localparam int unsigned GroundYDef = 480;

  // Two-digit BCD values order the same as their concatenated nibbles.
  function automatic logic bcd_gt(input logic [3:0] a_tens, input logic [3:0] a_ones,
                                  input logic [3:0] b_tens, input logic [3:0] b_ones);
    return {a_tens, a_ones} > {b_tens, b_ones};
  endfunction

endpackage

// File: rtl/collision_score_if.sv
// Game-state bus between the position sources, collision_score and the display stage.
// COLLISION_SCORE_HISCORE_EN adds the high-score digits.
interface collision_score_if;
  logic       Start;
  logic [9:0] PipePosX;
  logic [9:0] PipePosY;
  logic [9:0] BirdPosY;
  logic       Playing;
  logic       Lost;
  logic       ScoreInc;
  logic [3:0] ScoreTens;
  logic [3:0] ScoreOnes;
`ifdef COLLISION_SCORE_HISCORE_EN
  logic [3:0] HiTens;
  logic [3:0] HiOnes;

  modport master (
    output Start, PipePosX, PipePosY, BirdPosY,
    input  Playing, Lost, ScoreInc, ScoreTens, ScoreOnes, HiTens, HiOnes
  );
  modport slave (
    input  Start, PipePosX, PipePosY, BirdPosY,
    output Playing, Lost, ScoreInc, ScoreTens, ScoreOnes, HiTens, HiOnes
  );
`else
  modport master (
    output Start, PipePosX, PipePosY, BirdPosY,
    input  Playing, Lost, ScoreInc, ScoreTens, ScoreOnes
  );
  modport slave (
    input  Start, PipePosX, PipePosY, BirdPosY,
    output Playing, Lost, ScoreInc, ScoreTens, ScoreOnes
  );
`endif
endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with clear, parallel load and increment that saturates at 99.
module bcd_counter2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] tens_q, ones_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (clear) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (load) begin
      tens_q <= load_tens;
      ones_q <= load_ones;
    end else if (inc) begin
      if (tens_q == 4'd9 && ones_q == 4'd9) begin
        tens_q <= tens_q;
        ones_q <= ones_q;
      end else if (ones_q == 4'd9) begin
        ones_q <= 4'd0;
        tens_q <= tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/collision_score.sv
// Collision detection, game play/lost FSM and BCD score keeping for the flappy game.
// Optional high-score tracking is enabled by defining COLLISION_SCORE_HISCORE_EN.
module collision_score
  import flappy_pkg::*;
#(
  parameter int unsigned BIRD_X   = BirdXDef,
  parameter int unsigned BIRD_W   = BirdWDef,
  parameter int unsigned BIRD_H   = BirdHDef,
  parameter int unsigned PIPE_W   = PipeWDef,
  parameter int unsigned GAP_H    = GapHDef,
  parameter int unsigned GROUND_Y = GroundYDef
) (
  input logic              Clk,
  input logic              Reset,
  collision_score_if.slave bus
);

  localparam logic [10:0] BirdLeft  = 11'(BIRD_X);
  localparam logic [10:0] BirdRight = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] BirdH     = 11'(BIRD_H);
  localparam logic [10:0] PipeW     = 11'(PIPE_W);
  localparam logic [10:0] GapH      = 11'(GAP_H);
  localparam logic [10:0] GroundY   = 11'(GROUND_Y);

  // Stage 1: geometry compares, all 11 bits wide so sums never wrap.
  logic [10:0] pipe_x, pipe_y, bird_y, bird_bottom, pipe_right, gap_bottom;
  logic        xov, vmiss, gnd, hit_now, pass_now;

  always_comb begin
    pipe_x      = {1'b0, bus.PipePosX};
    pipe_y      = {1'b0, bus.PipePosY};
    bird_y      = {1'b0, bus.BirdPosY};
    bird_bottom = bird_y + BirdH;
    pipe_right  = pipe_x + PipeW;
    gap_bottom  = pipe_y + GapH;
    xov         = (pipe_x < BirdRight) && (pipe_right > BirdLeft);
    vmiss       = (bird_y < pipe_y) || (bird_bottom > gap_bottom);
    gnd         = bird_bottom >= GroundY;
    hit_now     = (xov && vmiss) || gnd;
    pass_now    = pipe_right < BirdLeft;
  end

  logic hit_q, pass_q, pass_d_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_q    <= 1'b0;
      pass_q   <= 1'b0;
      pass_d_q <= 1'b0;
    end else begin
      hit_q    <= hit_now;
      pass_q   <= pass_now;
      pass_d_q <= pass_q;
    end
  end

  // Stage 2: game FSM. Counter controls are decoded here so they land on the same edge.
  game_state_e state_q;
  logic        playing_q, lost_q, inc_q;
  logic        score_clear, score_inc, game_end;
  logic [3:0]  score_tens, score_ones;

  always_comb begin
    score_clear = (state_q == StIdle) && bus.Start;
    score_inc   = (state_q == StPlay) && bus.Start && !hit_q && pass_q && !pass_d_q;
    game_end    = (state_q == StPlay) && (!bus.Start || hit_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      playing_q <= 1'b0;
      lost_q    <= 1'b0;
      inc_q     <= 1'b0;
    end else begin
      inc_q <= score_inc;
      unique case (state_q)
        StIdle: begin
          if (bus.Start) begin
            state_q   <= StPlay;
            playing_q <= 1'b1;
          end
        end
        StPlay: begin
          if (!bus.Start) begin
            state_q   <= StIdle;
            playing_q <= 1'b0;
          end else if (hit_q) begin
            state_q   <= StLost;
            playing_q <= 1'b0;
            lost_q    <= 1'b1;
          end
        end
        StLost: begin
          if (!bus.Start) begin
            state_q <= StIdle;
            lost_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          playing_q <= 1'b0;
          lost_q    <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter2 u_score (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (score_clear),
    .inc       (score_inc),
    .load      (1'b0),
    .load_tens (4'd0),
    .load_ones (4'd0),
    .tens      (score_tens),
    .ones      (score_ones)
  );

  assign bus.Playing   = playing_q;
  assign bus.Lost      = lost_q;
  assign bus.ScoreInc  = inc_q;
  assign bus.ScoreTens = score_tens;
  assign bus.ScoreOnes = score_ones;

`ifdef COLLISION_SCORE_HISCORE_EN
  logic       hi_load;
  logic [3:0] hi_tens, hi_ones;

  // Score is stable on the leaving edge, so it can be captured as the new best directly.
  assign hi_load = game_end && bcd_gt(score_tens, score_ones, hi_tens, hi_ones);

  bcd_counter2 u_hiscore (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (1'b0),
    .inc       (1'b0),
    .load      (hi_load),
    .load_tens (score_tens),
    .load_ones (score_ones),
    .tens      (hi_tens),
    .ones      (hi_ones)
  );

  assign bus.HiTens = hi_tens;
  assign bus.HiOnes = hi_ones;
`endif

endmodule

// File: tb/tb_collision_score.sv
// Randomised and directed scoreboard bench for collision_score; a game-rule reference model
// predicts the outputs for each clock edge and a monitor checks them after that edge.
module tb_collision_score;

  localparam int BX = 200, BW = 20, BH = 20, PW = 50, GH = 120, GY = 480;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  collision_score_if bus ();

  collision_score dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned edge_no;
    bit          playing;
    bit          lost;
    bit          inc;
    int          score;
    int          hi;
  } exp_t;

  exp_t exp_q[$];
  int unsigned edge_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // Reference model: game rules in plain integers.
  localparam int Idle = 0, Play = 1, Lost = 2;
  int m_state, m_score, m_hi;
  bit seen_hit_1, seen_pass_1, seen_pass_2;  // conditions from one and two cycles back

  function automatic bit ref_hit(int px, int py, int by);
    bit xov, vmiss, gnd;
    xov   = (px < BX + BW) && (px + PW > BX);
    vmiss = (by < py) || (by + BH > py + GH);
    gnd   = (by + BH >= GY);
    return (xov && vmiss) || gnd;
  endfunction

  function automatic bit ref_pass(int px);
    return (px + PW < BX);
  endfunction

  function automatic int to_bcd(int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    m_state = Idle;
    m_score = 0;
    seen_hit_1 = 0;
    seen_pass_1 = 0;
    seen_pass_2 = 0;
  endtask

  task automatic end_game();
    if (m_score > m_hi) m_hi = m_score;
  endtask

  // Drive one cycle of inputs, predict the outputs after the coming edge, then take that edge.
  task automatic step(bit st, int px, int py, int by);
    exp_t e;
    bit inc;
    bus.Start    = st;
    bus.PipePosX = 10'(px);
    bus.PipePosY = 10'(py);
    bus.BirdPosY = 10'(by);
    inc = 0;
    case (m_state)
      Idle: if (st) begin m_state = Play; m_score = 0; end
      Play: begin
        if (!st) begin end_game(); m_state = Idle; end
        else if (seen_hit_1) begin end_game(); m_state = Lost; end
        else if (seen_pass_1 && !seen_pass_2) begin
          inc = 1;
          if (m_score < 99) m_score++;
        end
      end
      default: if (!st) m_state = Idle;
    endcase
    seen_pass_2 = seen_pass_1;
    seen_pass_1 = ref_pass(px);
    seen_hit_1  = ref_hit(px, py, by);
    e.edge_no = edge_cnt + 1;
    e.playing = (m_state == Play);
    e.lost    = (m_state == Lost);
    e.inc     = inc;
    e.score   = to_bcd(m_score);
    e.hi      = to_bcd(m_hi);
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  // Monitor: after each edge, check every prediction made for that edge.
  initial begin
    exp_t e;
    int got_score, got_hi;
    bit bad;
    forever begin
      @(posedge Clk);
      #3;
      while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
        e = exp_q.pop_front();
        got_score = {24'd0, bus.ScoreTens, bus.ScoreOnes};
        got_hi = e.hi;
`ifdef COLLISION_SCORE_HISCORE_EN
        got_hi = {24'd0, bus.HiTens, bus.HiOnes};
`endif
        bad = (e.edge_no != edge_cnt) || (bus.Playing !== e.playing) || (bus.Lost !== e.lost) ||
              (bus.ScoreInc !== e.inc) || (got_score != e.score) || (got_hi != e.hi);
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL outputs edge %0d (want %0d): got play=%0b lost=%0b inc=%0b score=%02h hi=%02h, expected play=%0b lost=%0b inc=%0b score=%02h hi=%02h",
                   edge_cnt, e.edge_no, bus.Playing, bus.Lost, bus.ScoreInc, got_score, got_hi,
                   e.playing, e.lost, e.inc, e.score, e.hi);
        end
      end
    end
  end

  task automatic check_val(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic check_all_zero(string name);
    int got;
    got = {21'd0, bus.Playing, bus.Lost, bus.ScoreInc, bus.ScoreTens, bus.ScoreOnes};
    check_val(name, got, 0);
  endtask

  task automatic start_game();
    repeat (2) step(0, 1000, 200, 250);
    step(1, 1000, 200, 250);
  endtask

  task automatic do_pass();
    repeat (2) step(1, 100, 200, 250);
    repeat (2) step(1, 1000, 200, 250);
  endtask

  task automatic crash();
    repeat (3) step(1, 1000, 200, 470);
  endtask

  task automatic play_game(int passes);
    start_game();
    repeat (passes) do_pass();
    crash();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Start = 0;
    bus.PipePosX = 10'd1000;
    bus.PipePosY = 10'd200;
    bus.BirdPosY = 10'd250;
    m_hi = 0;
    model_reset();
    #2;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge Clk);
    #1;
    Reset = 0;

    // Two safe sweeps of the pipe, one point each.
    start_game();
    repeat (2) begin
      for (int x = 1000; x >= 0; x--) repeat (4) step(1, x, 200, 250);
    end
    #4;
    check_val("sweep_score", {bus.ScoreTens, bus.ScoreOnes}, 'h02);
    check_val("sweep_lost", bus.Lost, 0);

    // Pipe overlap: 221 misses, 210 hits.
    start_game();
    repeat (4) step(1, 221, 200, 190);
    #4;
    check_val("no_overlap_lost", bus.Lost, 0);
    repeat (3) step(1, 210, 200, 190);
    #4;
    check_val("pipe_hit_lost", bus.Lost, 1);
    check_val("pipe_hit_playing", bus.Playing, 0);

    // Ground line with the pipe parked.
    start_game();
    repeat (4) step(1, 1000, 200, 459);
    #4;
    check_val("above_ground", bus.Lost, 0);
    repeat (3) step(1, 1000, 200, 460);
    #4;
    check_val("ground_hit", bus.Lost, 1);

    // Hit and pass edge together: hit wins.
    start_game();
    repeat (3) do_pass();
    repeat (3) step(1, 100, 200, 470);
    #4;
    check_val("simul_score", {bus.ScoreTens, bus.ScoreOnes}, 'h03);
    check_val("simul_lost", bus.Lost, 1);

    // Saturation at 99.
    start_game();
    repeat (100) do_pass();
    #4;
    check_val("saturate", {bus.ScoreTens, bus.ScoreOnes}, 'h99);

    // Async reset mid-play at 37.
    start_game();
    repeat (37) do_pass();
    #4;
    check_val("pre_reset_score", {bus.ScoreTens, bus.ScoreOnes}, 'h37);
    Reset = 1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge Clk);
    #1;
    Reset = 0;
    m_hi = 0;
    model_reset();

    // High score across games.
    play_game(12);
    play_game(5);
    #4;
`ifdef COLLISION_SCORE_HISCORE_EN
    check_val("hi_after_5", {bus.HiTens, bus.HiOnes}, 'h12);
`endif
    play_game(15);
    #4;
`ifdef COLLISION_SCORE_HISCORE_EN
    check_val("hi_after_15", {bus.HiTens, bus.HiOnes}, 'h15);
`else
    check_val("score_15", {bus.ScoreTens, bus.ScoreOnes}, 'h15);
`endif

    // Random play.
    for (int i = 0; i < 600; i++) begin
      int px;
      px = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(0, 300);
      step($urandom_range(0, 15) != 0, px, $urandom_range(100, 300), $urandom_range(100, 470));
    end

    repeat (3) step(0, 1000, 200, 250);
    #4;
    check_val("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
